// File: rtl/bcd_entry_ctrl.sv
// Cursor-based BCD value editor driven by debounced button pulses; commits on enter.
// Optional idle auto-abort in EDIT is enabled by defining BCD_ENTRY_TIMEOUT_EN.
module bcd_entry_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned VW = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_enter,
  output logic [VW-1:0] value_out,
  output logic [VW-1:0] committed,
  output logic [CW-1:0] cursor,
  output logic          editing,
  output logic          commit_p,
  output logic          abort_p
);

  typedef enum logic [1:0] {
    StIdle,
    StEdit,
    StCommit
  } state_e;

  typedef enum logic [2:0] {
    ActNone,
    ActEnter,
    ActUp,
    ActDown,
    ActLeft,
    ActRight
  } action_e;

  // Bit order doubles as priority order: enter highest, right lowest.
  localparam int unsigned BEnter = 4;
  localparam int unsigned BUp    = 3;
  localparam int unsigned BDown  = 2;
  localparam int unsigned BLeft  = 1;
  localparam int unsigned BRight = 0;

  state_e        state_q, state_d;
  logic [4:0]    btn_lvl;
  logic [4:0]    prev_q, prev_d;
  logic [4:0]    edge_q, edge_d;
  logic [VW-1:0] working_q, working_d;
  logic [VW-1:0] committed_q, committed_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic [3:0]    cur_digit;
  action_e       act;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  assign btn_lvl = {btn_enter, btn_up, btn_down, btn_left, btn_right};

  // Edge detection is registered, so an action lands one cycle after the edge is seen.
  always_comb begin
    prev_d = btn_lvl;
    edge_d = btn_lvl & ~prev_q;
  end

  always_comb begin
    act = ActNone;
    if (edge_q[BEnter]) begin
      act = ActEnter;
    end else if (edge_q[BUp]) begin
      act = ActUp;
    end else if (edge_q[BDown]) begin
      act = ActDown;
    end else if (edge_q[BLeft]) begin
      act = ActLeft;
    end else if (edge_q[BRight]) begin
      act = ActRight;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cursor_q == CW'(i)) begin
        cur_digit = working_q[4*i +: 4];
      end
    end
  end

`ifdef BCD_ENTRY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          abort_q, abort_d;
`endif

  always_comb begin
    state_d     = state_q;
    working_d   = working_q;
    committed_d = committed_q;
    cursor_d    = cursor_q;
`ifdef BCD_ENTRY_TIMEOUT_EN
    timer_d     = timer_q;
    abort_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (act == ActEnter) begin
          state_d   = StEdit;
          working_d = committed_q;
          cursor_d  = '0;
`ifdef BCD_ENTRY_TIMEOUT_EN
          timer_d   = '0;
`endif
        end
      end

      StEdit: begin
        unique case (act)
          ActEnter: state_d = StCommit;
          ActUp, ActDown: begin
            for (int i = 0; i < int'(DIGITS); i++) begin
              if (cursor_q == CW'(i)) begin
                working_d[4*i +: 4] = (act == ActUp) ? bcd_inc(cur_digit) : bcd_dec(cur_digit);
              end
            end
          end
          ActLeft: begin
            cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);
          end
          ActRight: begin
            cursor_d = (cursor_q == '0) ? CW'(DIGITS - 1) : cursor_q - CW'(1);
          end
          default: ;
        endcase
`ifdef BCD_ENTRY_TIMEOUT_EN
        // An action in the expiry cycle reloads the timer and suppresses the abort.
        if (act != ActNone) begin
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = StIdle;
          working_d = committed_q;
          abort_d   = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end

      StCommit: begin
        committed_d = working_q;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      edge_q      <= '0;
      working_q   <= '0;
      committed_q <= '0;
      cursor_q    <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      edge_q      <= edge_d;
      working_q   <= working_d;
      committed_q <= committed_d;
      cursor_q    <= cursor_d;
    end
  end

`ifdef BCD_ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      abort_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      abort_q <= abort_d;
    end
  end

  assign abort_p = abort_q;
`else
  assign abort_p = 1'b0;
`endif

  assign value_out = (state_q == StIdle) ? committed_q : working_q;
  assign committed = committed_q;
  assign cursor    = cursor_q;
  assign editing   = (state_q == StEdit);
  assign commit_p  = (state_q == StCommit);

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed bench for bcd_entry_ctrl (DIGITS=4, TIMEOUT_CYC=20) with hand-computed expectations.
module tb_bcd_entry_ctrl;

  localparam logic [4:0] E = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic        btn_right = 1'b0, btn_enter = 1'b0;
  logic [15:0] value_out, committed;
  logic [1:0]  cursor;
  logic        editing, commit_p, abort_p;

  int n_cmp = 0;
  int n_bad = 0;
  int n_commit = 0;
  int n_abort = 0;
  int snap_c, snap_a;

  bcd_entry_ctrl #(
    .DIGITS     (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_enter(btn_enter),
    .value_out(value_out),
    .committed(committed),
    .cursor   (cursor),
    .editing  (editing),
    .commit_p (commit_p),
    .abort_p  (abort_p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit_p) n_commit++;
    if (abort_p) n_abort++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_enter, btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    set_btn(m);
    repeat (hold) @(negedge clk);
    set_btn(5'b0);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_val("rst_value", value_out, 16'h0000);
    check_val("rst_committed", committed, 16'h0000);
    check_val("rst_cursor", cursor, 2'd0);
    check_val("rst_editing", editing, 1'b0);
    check_val("rst_commit_p", commit_p, 1'b0);
    check_val("rst_abort_p", abort_p, 1'b0);

    // Basic entry and commit
    press(E, 1);
    check_val("enter_editing", editing, 1'b1);
    repeat (3) press(U, 1);
    press(L, 1);
    repeat (7) press(U, 1);
    check_val("work_0073", value_out, 16'h0073);
    check_val("cursor_1", cursor, 2'd1);
    snap_c = n_commit;
    press(E, 1);
    check_val("commit_pulses", n_commit - snap_c, 1);
    check_val("committed_0073", committed, 16'h0073);
    check_val("idle_after_commit", editing, 1'b0);

    // Digit and cursor wrap
    do_reset();
    press(E, 1);
    press(D, 1);
    check_val("down_wrap_9", value_out, 16'h0009);
    press(U, 1);
    check_val("up_wrap_0", value_out, 16'h0000);
    repeat (4) press(L, 1);
    check_val("left_wrap_cursor", cursor, 2'd0);
    press(R, 1);
    check_val("right_wrap_cursor", cursor, 2'd3);
    press(U, 1);
    check_val("up_digit3", value_out, 16'h1000);

    // Priority and held button
    press(U | D, 1);
    check_val("up_beats_down", value_out, 16'h2000);
    press(U, 50);
    check_val("held_up_once", value_out, 16'h3000);
    snap_c = n_commit;
    press(E | L, 1);
    check_val("enter_left_commit", n_commit - snap_c, 1);
    check_val("enter_left_cursor", cursor, 2'd3);
    check_val("enter_left_committed", committed, 16'h3000);
    press(U, 1);
    check_val("idle_ignores_up", value_out, 16'h3000);
    check_val("idle_stays_idle", editing, 1'b0);

    // Reset mid-edit
    do_reset();
    press(E, 1);
    press(U, 1);
    press(L, 1);
    press(U, 1);
    press(E, 1);
    check_val("committed_0011", committed, 16'h0011);
    press(E, 1);
    press(U, 1);
    press(L, 1);
    repeat (3) press(U, 1);
    check_val("work_0042", value_out, 16'h0042);
    check_val("committed_still_0011", committed, 16'h0011);
    do_reset();
    check_val("midrst_value", value_out, 16'h0000);
    check_val("midrst_committed", committed, 16'h0000);
    check_val("midrst_editing", editing, 1'b0);
    check_val("midrst_cursor", cursor, 2'd0);

    // Enter held across reset release counts as an edge
    set_btn(E);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    set_btn(5'b0);
    repeat (4) @(negedge clk);
    #1;
    check_val("held_enter_after_rst", editing, 1'b1);

    // Idle behaviour in EDIT
    snap_a = n_abort;
    press(U, 1);
    check_val("edit_up_0001", value_out, 16'h0001);
`ifdef BCD_ENTRY_TIMEOUT_EN
    repeat (40) @(negedge clk);
    #1;
    check_val("timeout_abort_pulses", n_abort - snap_a, 1);
    check_val("timeout_editing", editing, 1'b0);
    check_val("timeout_committed", committed, 16'h0000);
    check_val("timeout_value", value_out, 16'h0000);
`else
    repeat (100) @(negedge clk);
    #1;
    check_val("no_timeout_editing", editing, 1'b1);
    check_val("no_timeout_abort", n_abort - snap_a, 0);
    check_val("no_timeout_value", value_out, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
